// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//
// Front end of the single-issue core. Holds the fetch PC, issues
// word-addressed requests to instruction memory, and buffers returned
// instructions (each tagged with its PC) in a small FIFO for decode.
// A taken-branch redirect flushes the FIFO, marks every in-flight response
// as stale so it is dropped on return, and restarts fetch at the new PC.
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous, active-low reset
//   redirect_valid  taken branch/jump, load redirect_pc
//   redirect_pc     branch target
//   imem_req        request valid
//   imem_addr       request address (word address)
//   imem_ready      memory accepts the request this cycle
//   imem_rvalid     response valid (in order, latency >= 1)
//   imem_rdata      response instruction
//   out_valid       FIFO head valid
//   out_instr       head instruction
//   out_pc          head PC
//   out_ready       decode consumes the head
//
// Optional build macro:
//   FETCH_TRACE_EN  prints every FIFO push and every redirect.
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              out_ready
);

    localparam int          PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW    = PW + 1;
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_resp_pc;
    logic [CW-1:0]     r_outstanding;
    logic [CW-1:0]     r_drop_cnt;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [ADDR_W-1:0] r_pc_mem    [DEPTH];
    logic [DATA_W-1:0] r_instr_mem [DEPTH];

    logic          w_credit;
    logic          w_req;
    logic          w_accept;
    logic          w_push;
    logic          w_drop;
    logic          w_valid;
    logic          w_pop;
    logic [CW-1:0] w_out_next;
    logic [CW-1:0] w_count_next;
    logic [CW:0]   w_total_next;

    // Credit: buffered entries plus in-flight requests must stay below DEPTH,
    // so every response that can come back is guaranteed a FIFO slot.
    assign w_credit = ({1'b0, r_count} + {1'b0, r_outstanding}) < LIMIT;

    // No request while a redirect is being taken or while reset is asserted.
    assign w_req    = reset && (r_state == FETCH) && w_credit && !redirect_valid;
    assign w_accept = w_req && imem_ready;

    // A response arriving with a redirect is stale by definition.
    assign w_drop   = imem_rvalid && (r_drop_cnt != '0);
    assign w_push   = imem_rvalid && (r_drop_cnt == '0) && !redirect_valid;

    assign w_valid  = reset && (r_count != '0);
    assign w_pop    = w_valid && out_ready && !redirect_valid;

    assign w_out_next   = r_outstanding + CW'(w_accept) - CW'(imem_rvalid);
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    assign w_total_next = {1'b0, w_count_next} + {1'b0, w_out_next};

    assign imem_req  = w_req;
    assign imem_addr = r_fetch_pc;
    assign out_valid = w_valid;
    assign out_instr = w_valid ? r_instr_mem[r_rd_ptr] : '0;
    assign out_pc    = w_valid ? r_pc_mem[r_rd_ptr]    : '0;

    // Control state: PCs, counters, pointers, FSM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_fetch_pc    <= '0;
            r_resp_pc     <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            r_outstanding <= w_out_next;

            if (redirect_valid) begin
                // Everything still in flight after this edge is stale.
                r_fetch_pc <= redirect_pc;
                r_resp_pc  <= redirect_pc;
                r_drop_cnt <= w_out_next;
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_state    <= FETCH;
`ifdef FETCH_TRACE_EN
                $display("instr_fetch_unit: redirect to %d", redirect_pc);
`endif
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 1'b1;
                end
                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt - 1'b1;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 1'b1;
                    r_wr_ptr  <= r_wr_ptr + 1'b1;
`ifdef FETCH_TRACE_EN
                    $display("instr_fetch_unit: pc = %d instr = %h", r_resp_pc, imem_rdata);
`endif
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_count <= w_count_next;

                // FULL is entered/left on the credit seen after this edge,
                // so there is no idle bubble when a slot frees up.
                case (r_state)
                    IDLE:    r_state <= FETCH;
                    FETCH:   if (w_total_next >= LIMIT) r_state <= FULL;
                    FULL:    if (w_total_next < LIMIT)  r_state <= FETCH;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // FIFO storage is data only and needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= r_resp_pc;
            r_instr_mem[r_wr_ptr] <= imem_rdata;
        end
    end

endmodule
